// File: rtl/hsi_mse_pkg.sv
// Shared constants for the hyperspectral MSE engine.
package hsi_mse_pkg;
    localparam int HM_WORD_WIDTH     = 32;
    localparam int HM_DATA_WIDTH     = 16;
    localparam int HM_DATA_WIDTH_MUL = 32;
    localparam int HM_DATA_WIDTH_ACC = 48;
    localparam int HM_HSI_BANDS      = 128;

    localparam int HM_DATA_PER_WORD  = HM_WORD_WIDTH / HM_DATA_WIDTH;
    localparam int HM_ELEMENTS       = HM_HSI_BANDS / HM_DATA_PER_WORD;
    localparam int HM_SHIFT          = $clog2(HM_HSI_BANDS);
endpackage

// File: rtl/hsi_mse_sq_diff.sv
// One lane: squared absolute difference of two unsigned samples.
module hsi_mse_sq_diff #(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_WIDTH_MUL = 32
) (
    input  logic [DATA_WIDTH-1:0]     i_a,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic [DATA_WIDTH_MUL-1:0] o_sq
);
    logic [DATA_WIDTH-1:0]   w_d;
    logic [2*DATA_WIDTH-1:0] w_p;

    assign w_d  = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    assign w_p  = {{DATA_WIDTH{1'b0}}, w_d} * {{DATA_WIDTH{1'b0}}, w_d};
    assign o_sq = DATA_WIDTH_MUL'(w_p);
endmodule

// File: rtl/hsi_mse.sv
// Streaming MSE of two packed hyperspectral vectors; result floor(sum/HSI_BANDS)
// pulses one cycle after the last word leaves the accumulate stage.
module hsi_mse
    import hsi_mse_pkg::*;
#(
    parameter int WORD_WIDTH     = HM_WORD_WIDTH,
    parameter int DATA_WIDTH     = HM_DATA_WIDTH,
    parameter int DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL,
    parameter int DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC,
    parameter int HSI_BANDS      = HM_HSI_BANDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_vctr,
    input  logic [WORD_WIDTH-1:0] element_a,
    input  logic [WORD_WIDTH-1:0] element_b,
    input  logic                  element_valid,
    output logic [WORD_WIDTH-1:0] mse,
    output logic                  mse_valid
);
    localparam int DPW      = WORD_WIDTH / DATA_WIDTH;
    localparam int ELEMENTS = HSI_BANDS / DPW;
    localparam int SHIFT    = $clog2(HSI_BANDS);
    localparam int CW       = $clog2(ELEMENTS + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [DPW-1:0][DATA_WIDTH_MUL-1:0] w_sq;
    logic [DATA_WIDTH_ACC-1:0]          w_word_sum;

    for (genvar k = 0; k < DPW; k++) begin : g_lane
        hsi_mse_sq_diff #(
            .DATA_WIDTH    (DATA_WIDTH),
            .DATA_WIDTH_MUL(DATA_WIDTH_MUL)
        ) u_sq (
            .i_a (element_a[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_b (element_b[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_sq(w_sq[k])
        );
    end

    always_comb begin
        w_word_sum = '0;
        for (int k = 0; k < DPW; k++)
            w_word_sum = w_word_sum + DATA_WIDTH_ACC'(w_sq[k]);
    end

    // Word acceptance / framing
    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_first;
    logic          w_accept;
    logic [CW-1:0] w_cnt_next;
    logic          w_last;

    assign w_first    = element_valid && start_vctr;
    assign w_accept   = element_valid && (start_vctr || (r_state == ACCUM));
    assign w_cnt_next = start_vctr ? CW'(1) : (r_cnt + CW'(1));
    assign w_last     = w_accept && (w_cnt_next == CW'(ELEMENTS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt   <= w_cnt_next;
            r_state <= w_last ? IDLE : ACCUM;
        end
    end

    // Stage 1: registered word sum and framing flags
    logic                      r_s1_vld;
    logic                      r_s1_first;
    logic                      r_s1_last;
    logic [DATA_WIDTH_ACC-1:0] r_s1_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
        end else begin
            r_s1_vld   <= w_accept;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            if (w_accept)
                r_s1_sum <= w_word_sum;
        end
    end

    // Stage 2: accumulate; a first word discards any partial sum from a restart
    logic [DATA_WIDTH_ACC-1:0] r_acc;
    logic [DATA_WIDTH_ACC-1:0] w_total;
    logic [WORD_WIDTH-1:0]     r_mse;
    logic                      r_mse_vld;

    assign w_total = (r_s1_first ? '0 : r_acc) + r_s1_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mse     <= '0;
            r_mse_vld <= 1'b0;
        end else begin
            r_mse_vld <= r_s1_vld && r_s1_last;
            if (r_s1_vld)
                r_acc <= w_total;
            if (r_s1_vld && r_s1_last)
                r_mse <= WORD_WIDTH'(w_total >> SHIFT);
        end
    end

    assign mse       = r_mse;
    assign mse_valid = r_mse_vld;
endmodule

// File: tb/tb_hsi_mse.sv
// Scoreboard bench for hsi_mse: driver pushes expected MSE and arrival cycle,
// negedge monitor pops on every mse_valid.
module tb_hsi_mse;
    localparam int ELEM = 64;

    logic        clk;
    logic        rst_n;
    logic        start_vctr;
    logic [31:0] element_a;
    logic [31:0] element_b;
    logic        element_valid;
    logic [31:0] mse;
    logic        mse_valid;

    hsi_mse dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_vctr   (start_vctr),
        .element_a    (element_a),
        .element_b    (element_b),
        .element_valid(element_valid),
        .mse          (mse),
        .mse_valid    (mse_valid)
    );

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] va[ELEM];
    logic [31:0] vb[ELEM];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && mse_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_mse_valid: got mse 0x%08h at cycle %0d, expected none", mse, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mse_value", mse, e.val);
                check("mse_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic [31:0] a, input logic [31:0] b);
        start_vctr    = s;
        element_valid = v;
        element_a     = a;
        element_b     = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Sends the first n words of va/vb; a full vector registers its expected result.
    task automatic send_vec(input int n, input logic [31:0] exp_val);
        for (int w = 0; w < n; w++) begin
            if (n == ELEM && w == ELEM - 1) sb_q.push_back('{exp_val, cyc + 2});
            drive(w == 0, 1'b1, va[w], vb[w]);
        end
    endtask

    task automatic fill_const(input logic [31:0] a, input logic [31:0] b);
        for (int w = 0; w < ELEM; w++) begin
            va[w] = a;
            vb[w] = b;
        end
    endtask

    task automatic fill_rand();
        for (int w = 0; w < ELEM; w++) begin
            va[w] = $urandom;
            vb[w] = $urandom;
        end
    endtask

    function automatic logic [31:0] model_mse();
        longint unsigned sum = 0;
        for (int w = 0; w < ELEM; w++) begin
            for (int k = 0; k < 2; k++) begin
                longint unsigned x, y, d;
                x = 64'(va[w][k*16 +: 16]);
                y = 64'(vb[w][k*16 +: 16]);
                d = (x > y) ? x - y : y - x;
                sum += d * d;
            end
        end
        return 32'(sum / 128);
    endfunction

    initial begin
        rst_n = 1'b0;
        start_vctr = 1'b0;
        element_valid = 1'b0;
        element_a = '0;
        element_b = '0;
        repeat (3) @(negedge clk);
        check("reset_mse", mse, 32'h0);
        check("reset_mse_valid", 32'(mse_valid), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Hand-computed directed vectors
        fill_const(32'h0005_0003, 32'h0001_0001); send_vec(ELEM, 32'd10); idle(4);
        fill_const(32'h0000_0001, 32'h0003_0000); send_vec(ELEM, 32'd5);  idle(4);
        fill_const(32'h1234_5678, 32'h1234_5678); send_vec(ELEM, 32'd0);  idle(4);
        fill_const(32'h0010_0020, 32'h0010_0020); vb[7] = 32'h0010_0021;
        send_vec(ELEM, 32'd0); idle(4);
        fill_const(32'hFFFF_FFFF, 32'h0000_0000); send_vec(ELEM, 32'hFFFE_0001);
        // Words ignored in IDLE while valid stays high with stale data
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);

        // Back-to-back random vectors, stale gaps and one zero-gap handoff
        fill_rand(); send_vec(ELEM, model_mse());
        drive(1'b0, 1'b1, va[ELEM-1], vb[ELEM-1]);
        drive(1'b0, 1'b1, va[ELEM-1], vb[ELEM-1]);
        fill_rand(); send_vec(ELEM, model_mse());
        fill_rand(); send_vec(ELEM, model_mse());
        drive(1'b0, 1'b1, va[ELEM-1], vb[ELEM-1]);

        // Restart at word 30 discards the partial vector
        fill_rand(); send_vec(30, 32'h0);
        fill_rand(); send_vec(ELEM, model_mse());
        idle(4);

        // Reset mid-vector at word 20
        fill_rand(); send_vec(20, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midreset_mse", mse, 32'h0);
        check("midreset_mse_valid", 32'(mse_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        fill_rand(); send_vec(ELEM, model_mse());
        idle(6);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
